// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle shared between the timing generator and draw stages.
// Counts and sync/blank flags all describe the same pixel.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out (
    output hcount, vcount,
    output hsync, vsync,
    output hblnk, vblnk
  );

  modport in (
    input hcount, vcount,
    input hsync, vsync,
    input hblnk, vblnk
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: 11-bit h/v counters with registered sync/blank.
// Define VGA_FRAME_START_EN to build the frame_start pulse (else tied 0).
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  vga_if.out   vga_out,
  output logic frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLK  = 11'(H_ACTIVE);
  localparam logic [10:0] V_BLK  = 11'(V_ACTIVE);

  // Sync windows kept as inclusive first/last so a 2048 total still fits.
  localparam logic [10:0] H_HS_ON   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_HS_LAST = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_VS_ON   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_VS_LAST = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit range");
  end

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        h_wrap;
  logic        v_wrap;

  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en) begin
      hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
      end
    end
  end

  // Flags decode the next counts so they land in the same cycle as them.
  always_comb begin
    hblnk_d = (hcount_d >= H_BLK);
    vblnk_d = (vcount_d >= V_BLK);
    hsync_d = (hcount_d >= H_HS_ON) && (hcount_d <= H_HS_LAST);
    vsync_d = (vcount_d >= V_VS_ON) && (vcount_d <= V_VS_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;

`ifdef VGA_FRAME_START_EN
  logic frame_start_q, frame_start_d;

  // Only a real wrap pulses; reset parks at (0,0) without one.
  always_comb begin
    frame_start_d = pix_en && h_wrap && v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;
`else
  assign frame_start = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800x600 timing
// plus a tiny-parameter instance for the full small raster.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_START_EN
  localparam logic FS_ON = 1'b1;
`else
  localparam logic FS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  logic fs;

  logic rst_s = 1'b1;
  logic pen_s = 1'b0;
  logic fs_s;

  vga_if u_if ();
  vga_if s_if ();

  vga_timing_gen u_dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .vga_out     (u_if),
    .frame_start (fs)
  );

  vga_timing_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_small (
    .clk         (clk),
    .rst         (rst_s),
    .pix_en      (pen_s),
    .vga_out     (s_if),
    .frame_start (fs_s)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic pen);
    pix_en = pen;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".hcount"}, 32'(u_if.hcount), 0);
    chk({tag, ".vcount"}, 32'(u_if.vcount), 0);
    chk({tag, ".hsync"}, 32'(u_if.hsync), 0);
    chk({tag, ".vsync"}, 32'(u_if.vsync), 0);
    chk({tag, ".hblnk"}, 32'(u_if.hblnk), 0);
    chk({tag, ".vblnk"}, 32'(u_if.vblnk), 0);
    chk({tag, ".fs"}, 32'(fs), 0);
  endtask

  initial begin
    int n;
    int hs_pulses, hs_bad, hs_len;
    int vs_pulses, vs_bad, vs_len;
    int cons_err, fs_cnt;
    bit done, hb_seen, vb_seen, wrap_seen;
    logic [10:0] ph, pv, h, v;
    logic phs, pvs, phb, pvb;
    logic [10:0] gate_exp [4];
    logic gate_pen [4];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");

    // First enabled edge after release
    rst = 1'b0;
    step(1'b1);
    chk("rel.hcount", 32'(u_if.hcount), 1);
    chk("rel.vcount", 32'(u_if.vcount), 0);
    chk("rel.fs", 32'(fs), 0);
    repeat (9) step(1'b1);
    chk("pre_gate.hcount", 32'(u_if.hcount), 10);

    // Enable gating from hcount 10
    gate_pen = '{1'b1, 1'b0, 1'b0, 1'b1};
    gate_exp = '{11'd11, 11'd11, 11'd11, 11'd12};
    for (int i = 0; i < 4; i++) begin
      step(gate_pen[i]);
      chk($sformatf("gate%0d.hcount", i), 32'(u_if.hcount), 32'(gate_exp[i]));
      chk($sformatf("gate%0d.fs", i), 32'(fs), 0);
    end
    chk("gate.vcount", 32'(u_if.vcount), 0);

    // Free run from (12,0) back to (0,0)
    n = 0;
    hs_pulses = 0; hs_bad = 0; hs_len = 0;
    vs_pulses = 0; vs_bad = 0; vs_len = 0;
    cons_err = 0; fs_cnt = 0;
    hb_seen = 0; vb_seen = 0; wrap_seen = 0; done = 0;
    while (!done && n < 1056 * 628 + 100) begin
      ph = u_if.hcount; pv = u_if.vcount;
      phs = u_if.hsync; pvs = u_if.vsync;
      phb = u_if.hblnk; pvb = u_if.vblnk;
      step(1'b1);
      n++;
      h = u_if.hcount; v = u_if.vcount;
      if (fs) fs_cnt++;
      if (u_if.hblnk !== (h >= 800)) cons_err++;
      if (u_if.vblnk !== (v >= 600)) cons_err++;
      if (u_if.hsync !== (h >= 840 && h <= 967)) cons_err++;
      if (u_if.vsync !== (v >= 601 && v <= 604)) cons_err++;
      if (u_if.hsync) begin
        if (!phs) begin
          hs_pulses++;
          if (h != 840) hs_bad++;
          hs_len = 0;
        end
        hs_len++;
      end else if (phs && hs_len != 128) begin
        hs_bad++;
      end
      if (u_if.vsync) begin
        if (!pvs) begin
          vs_pulses++;
          if (v != 601 || h != 0) vs_bad++;
          vs_len = 0;
        end
        vs_len++;
      end else if (pvs && vs_len != 4 * 1056) begin
        vs_bad++;
      end
      if (!hb_seen && ph == 799) begin
        hb_seen = 1;
        chk("hblnk_edge.hcount", 32'(h), 800);
        chk("hblnk_edge.before", 32'(phb), 0);
        chk("hblnk_edge.after", 32'(u_if.hblnk), 1);
      end
      if (!vb_seen && pv == 599 && v == 600) begin
        vb_seen = 1;
        chk("vblnk_edge.before", 32'(pvb), 0);
        chk("vblnk_edge.after", 32'(u_if.vblnk), 1);
      end
      if (ph == 1055 && pv == 627) begin
        wrap_seen = 1;
        chk("wrap.hcount", 32'(h), 0);
        chk("wrap.vcount", 32'(v), 0);
        chk("wrap.hblnk", 32'(u_if.hblnk), 0);
        chk("wrap.vblnk", 32'(u_if.vblnk), 0);
        chk("wrap.fs", 32'(fs), 32'(FS_ON));
      end
      if (h == 0 && v == 0) done = 1;
    end
    chk("run.returned", 32'(done), 1);
    chk("run.cycles", n, 1056 * 628 - 12);
    chk("run.wrap_seen", 32'(wrap_seen), 1);
    chk("run.hblnk_edge_seen", 32'(hb_seen), 1);
    chk("run.vblnk_edge_seen", 32'(vb_seen), 1);
    chk("run.hsync_pulses", hs_pulses, 628);
    chk("run.hsync_bad", hs_bad, 0);
    chk("run.vsync_pulses", vs_pulses, 1);
    chk("run.vsync_bad", vs_bad, 0);
    chk("run.consistency", cons_err, 0);
    chk("run.fs_count", fs_cnt, FS_ON ? 1 : 0);

    // Pulse lasts one cycle; then advance to (500,300)
    step(1'b1);
    chk("post_wrap.fs", 32'(fs), 0);
    n = 0;
    while (!(u_if.hcount == 500 && u_if.vcount == 300) && n < 301 * 1056) begin
      step(1'b1);
      n++;
    end
    chk("mid.reached_v", 32'(u_if.vcount), 300);
    chk("mid.reached_h", 32'(u_if.hcount), 500);

    // Asynchronous mid-frame reset, away from any clock edge
    #2 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1);
    chk("after_rst.hcount", 32'(u_if.hcount), 1);
    chk("after_rst.vcount", 32'(u_if.vcount), 0);
    chk("after_rst.fs", 32'(fs), 0);

    // Tiny raster: 8 x 5, hsync 5..6, vsync 3
    chk("small.rst.hcount", 32'(s_if.hcount), 0);
    chk("small.rst.hblnk", 32'(s_if.hblnk), 0);
    rst_s = 1'b0;
    pen_s = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      int eh, ev;
      @(posedge clk);
      @(negedge clk);
      eh = k % 8;
      ev = (k / 8) % 5;
      chk($sformatf("small%0d.hcount", k), 32'(s_if.hcount), eh);
      chk($sformatf("small%0d.vcount", k), 32'(s_if.vcount), ev);
      chk($sformatf("small%0d.hsync", k), 32'(s_if.hsync),
          32'(eh == 5 || eh == 6));
      chk($sformatf("small%0d.vsync", k), 32'(s_if.vsync), 32'(ev == 3));
      chk($sformatf("small%0d.hblnk", k), 32'(s_if.hblnk), 32'(eh >= 4));
      chk($sformatf("small%0d.vblnk", k), 32'(s_if.vblnk), 32'(ev >= 2));
      chk($sformatf("small%0d.fs", k), 32'(fs_s),
          32'(FS_ON && (k % 40 == 0)));
    end
    pen_s = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 40, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 128, meaning horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 88, meaning horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 600, meaning visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 1, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 4, meaning vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 23, meaning vertical back porch in lines.
REQ-009 The block SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-010 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-011 The block SHALL have port pix_en, input, 1 bit, pixel-advance enable; counters step only when high.
REQ-012 The block SHALL have port vga_out, vga_if.out, carrying hcount, vcount (11 bits each), hsync, vsync, hblnk and vblnk, consumed by draw stages.
REQ-013 The block SHALL have port frame_start, output, 1 bit, one-cycle pulse marking pixel (0,0).

Function
REQ-014 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
REQ-015 hcount SHALL increment by 1 on each clk edge with pix_en=1, and wrap from H_TOTAL-1 to 0.
REQ-016 vcount SHALL increment only on the edge where hcount wraps, and wrap from V_TOTAL-1 to 0 on the same edge as the final hcount wrap.
REQ-017 With pix_en=0, all vga_out fields and frame_start SHALL hold, except frame_start, which SHALL be 0.
REQ-018 hblnk SHALL be 1 iff hcount >= H_ACTIVE; vblnk SHALL be 1 iff vcount >= V_ACTIVE.
REQ-019 hsync SHALL be 1 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 840..967); vsync SHALL be 1 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default 601..604); polarity is positive.
REQ-020 All vga_out fields SHALL be registered and mutually consistent: sync and blank in a given cycle describe the hcount/vcount of that same cycle, with no combinational path from inputs to outputs.
REQ-021 Counter arithmetic SHALL be 11-bit unsigned; H_TOTAL and V_TOTAL SHALL not exceed 2048 (elaboration error otherwise).

Reset
REQ-022 While rst=1, the block SHALL drive hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0.
REQ-023 On the first clk edge with pix_en=1 after rst deasserts, hcount SHALL become 1; counting SHALL resume from (0,0) after mid-frame reset.

Configuration
REQ-024 With macro VGA_FRAME_START_EN defined, frame_start SHALL be 1 for exactly the one clk cycle in which the registered outputs first show hcount=0 and vcount=0 after a wrap, qualified by pix_en, and SHALL not pulse out of reset.
REQ-025 With VGA_FRAME_START_EN undefined, frame_start SHALL be tied 0 and its logic SHALL not be synthesised; all other behaviour is unchanged.

Verification
REQ-026 The bench SHALL cover free-run: pix_en=1 constantly, 1056*628 cycles -> exactly one hsync pulse per line of 128 cycles starting at hcount 840, exactly one vsync pulse of 4 lines starting at vcount 601, and the return to (0,0).
REQ-027 The bench SHALL cover the wrap corner: at hcount=1055, vcount=627 with pix_en=1 -> next cycle hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=1 (macro on) or 0 (macro off).
REQ-028 The bench SHALL cover enable gating: pix_en toggled 1,0,0,1 starting at hcount=10 -> hcount sequence 11,11,11,12 and frame_start stays 0.
REQ-029 The bench SHALL cover blanking edges: hcount 799->800 makes hblnk go 0->1, and vcount 599->600 makes vblnk go 0->1, in the same cycle as the count change.
REQ-030 The bench SHALL cover reset mid-frame: rst asserted asynchronously at (500,300) -> all outputs 0 immediately without a clk edge; after release, first pix_en edge gives hcount=1, vcount=0.
REQ-031 The bench SHALL cover non-default parameters: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 -> H_TOTAL=8, V_TOTAL=5, hsync high at hcount 5..6, vsync high at vcount 3.
